// File: rtl/arm_pkg.sv
// Shared definitions for the arming controller slice.
// Holds the FSM state encoding, parameter defaults and a counter-width helper.
package arm_pkg;

  localparam int unsigned CODE_W              = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
  localparam int unsigned ERROR_CYCLES_DEF    = 25000000;
  localparam int unsigned MAX_ATTEMPTS_DEF    = 3;
  localparam logic [CODE_W-1:0] ARM_CODE_DEF  = 4'hA;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ERROR  = 2'd1,
    ARMED  = 2'd2,
    LOCKED = 2'd3
  } arm_state_e;

  // Bits needed to hold the values 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arm_controller_if.sv
// Button/code/status bundle of the arming controller.
//   button_n        raw push button, low = pressed
//   code_sw         arming code switches
//   start_countdown one-cycle arm pulse
//   armed           high once armed
//   code_error      wrong-code indicator
//   locked_out      permanent lockout indicator
interface arm_controller_if;
  import arm_pkg::*;

  logic              button_n;
  logic [CODE_W-1:0] code_sw;
  logic              start_countdown;
  logic              armed;
  logic              code_error;
  logic              locked_out;

  modport master (
    output button_n, code_sw,
    input  start_countdown, armed, code_error, locked_out
  );

  modport slave (
    input  button_n, code_sw,
    output start_countdown, armed, code_error, locked_out
  );
endinterface

// File: rtl/arm_controller_debouncer.sv
// Push-button conditioner: two-flop synchroniser, debounce counter and
// released->pressed edge detect.
//   clk, async_nreset  clock / async active-low reset
//   button_n           raw asynchronous button, low = pressed
//   press              one-cycle pulse per debounced press
module debouncer
  import arm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic async_nreset,
  input  logic button_n,
  output logic press
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1, sync2;
  logic             level, level_d;
  logic [CNT_W-1:0] cnt;

  // Synchroniser, idles at released.
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= button_n;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES clocks in a row.
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      level <= 1'b1;
      cnt   <= '0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      level <= sync2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Registered falling-edge detect of the debounced level.
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      level_d <= 1'b1;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= level_d & ~level;
    end
  end

endmodule

// File: rtl/arm_controller.sv
// Arming controller: a debounced press with the right code arms the device
// (terminal), a wrong code shows code_error for ERROR_CYCLES clocks.
// Optional feature macro ARM_LOCKOUT_EN: the MAX_ATTEMPTS-th wrong code
// locks the device until reset.
//   clk, async_nreset  clock / async active-low reset
//   bus                arm_controller_if.slave (button, code, status outputs)
module arm_controller
  import arm_pkg::*;
#(
  parameter int unsigned       DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic [CODE_W-1:0] ARM_CODE        = ARM_CODE_DEF,
  parameter int unsigned       ERROR_CYCLES    = ERROR_CYCLES_DEF,
  parameter int unsigned       MAX_ATTEMPTS    = MAX_ATTEMPTS_DEF
) (
  input logic             clk,
  input logic             async_nreset,
  arm_controller_if.slave bus
);

  localparam int unsigned ERR_W = cnt_width(ERROR_CYCLES);
  localparam int unsigned ATT_W = cnt_width(MAX_ATTEMPTS + 1);
  localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'(ERROR_CYCLES - 1);
  localparam logic [ATT_W-1:0] ATT_MAX  = ATT_W'(MAX_ATTEMPTS);

  arm_state_e       state_q, state_nxt;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_nxt;
  logic [ATT_W-1:0] att_q, att_nxt;
  logic             press;
  logic             start_q, armed_q, code_error_q, locked_q;
  logic             start_nxt, armed_nxt, code_error_nxt, locked_nxt;

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
    .clk          (clk),
    .async_nreset (async_nreset),
    .button_n     (bus.button_n),
    .press        (press)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      state_q      <= IDLE;
      err_cnt_q    <= '0;
      att_q        <= '0;
      start_q      <= 1'b0;
      armed_q      <= 1'b0;
      code_error_q <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      err_cnt_q    <= err_cnt_nxt;
      att_q        <= att_nxt;
      start_q      <= start_nxt;
      armed_q      <= armed_nxt;
      code_error_q <= code_error_nxt;
      locked_q     <= locked_nxt;
    end
  end

  // Next state; code_sw is only looked at when a press arrives in IDLE.
  always_comb begin
    state_nxt   = state_q;
    err_cnt_nxt = err_cnt_q;
    att_nxt     = att_q;
    case (state_q)
      IDLE: begin
        if (press) begin
          if (bus.code_sw == ARM_CODE) begin
            state_nxt = ARMED;
          end else begin
            if (att_q != ATT_MAX) att_nxt = att_q + ATT_W'(1);
`ifdef ARM_LOCKOUT_EN
            state_nxt = (att_q >= ATT_W'(MAX_ATTEMPTS - 1)) ? LOCKED : ERROR;
`else
            state_nxt = ERROR;
`endif
            err_cnt_nxt = '0;
          end
        end
      end
      ERROR: begin
        if (err_cnt_q == ERR_LAST) state_nxt = IDLE;
        else err_cnt_nxt = err_cnt_q + ERR_W'(1);
      end
      ARMED:   state_nxt = ARMED;
      LOCKED:  state_nxt = LOCKED;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the flops line up with it.
  always_comb begin
    start_nxt      = (state_q == IDLE) && (state_nxt == ARMED);
    armed_nxt      = (state_nxt == ARMED);
    code_error_nxt = (state_nxt == ERROR) || (state_nxt == LOCKED);
`ifdef ARM_LOCKOUT_EN
    locked_nxt     = (state_nxt == LOCKED);
`else
    locked_nxt     = 1'b0;
`endif
  end

  assign bus.start_countdown = start_q;
  assign bus.armed           = armed_q;
  assign bus.code_error      = code_error_q;
  assign bus.locked_out      = locked_q;

endmodule
